lcd_frame_streamer: RTL and testbench

// Sits downstream of home_renderer and the game renderers, and feeds the ILI9341 panel over SPI.
// Per frame: sends the window setup (CASET/RASET/RAMWR), then streams LCD_W*LCD_H RGB565 pixels.

---
 rtl/lcd_frame_streamer_if.sv | 28 ++
 rtl/lcd_frame_streamer.sv | 167 ++++++++++++++++
 tb/tb_lcd_frame_streamer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_streamer_if.sv
// Streamer-side bus bundle: renderer pixel handshake plus the ILI9341 SPI lines.
// The master modport is the streamer; the slave modport is the renderer/panel side.
interface lcd_frame_streamer_if;
    logic [15:0] pixel_color;
    logic        framebufferClk;
    logic        lcd_sck;
    logic        lcd_mosi;
    logic        lcd_dc;
    logic        lcd_cs_n;

    modport master (
        input  pixel_color,
        output framebufferClk,
        output lcd_sck,
        output lcd_mosi,
        output lcd_dc,
        output lcd_cs_n
    );

    modport slave (
        output pixel_color,
        input  framebufferClk,
        input  lcd_sck,
        input  lcd_mosi,
        input  lcd_dc,
        input  lcd_cs_n
    );
endinterface

// File: rtl/lcd_frame_streamer.sv
// Streams one ILI9341 frame per request: CASET/RASET/RAMWR window header, then
// LCD_W*LCD_H RGB565 words, strobing framebufferClk once per captured pixel.
module lcd_frame_streamer #(
    parameter int LCD_W   = 240,
    parameter int LCD_H   = 320,
    parameter int SPI_DIV = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    lcd_frame_streamer_if.master   lcd,
    output logic                   busy,
    output logic                   frame_done
);

    typedef enum logic [1:0] {IDLE, HDR, PIX, DONE} state_e;

    localparam int              DIV_W     = $clog2(2 * SPI_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SPI_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SPI_DIV);
    localparam logic [16:0]     PIX_LAST  = 17'(LCD_W * LCD_H - 1);
    localparam logic [15:0]     W_END     = 16'(LCD_W - 1);
    localparam logic [15:0]     H_END     = 16'(LCD_H - 1);
    localparam logic [3:0]      HDR_BYTES = 4'd11;

    // Header byte table entry: {dc, byte}; dc=0 marks the three command bytes.
    function automatic logic [8:0] hdr_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    hdr_entry = {1'b0, 8'h2A};
            4'd3:    hdr_entry = {1'b1, W_END[15:8]};
            4'd4:    hdr_entry = {1'b1, W_END[7:0]};
            4'd5:    hdr_entry = {1'b0, 8'h2B};
            4'd8:    hdr_entry = {1'b1, H_END[15:8]};
            4'd9:    hdr_entry = {1'b1, H_END[7:0]};
            4'd10:   hdr_entry = {1'b0, 8'h2C};
            default: hdr_entry = {1'b1, 8'h00};
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       hdr_idx_q, hdr_idx_d;
    logic [16:0]      pix_cnt_q, pix_cnt_d;
    logic [15:0]      shreg_q, shreg_d;
    logic [1:0]       fb_cnt_q, fb_cnt_d;
    logic             fbclk_q, fbclk_d;
    logic             sck_q, sck_d;
    logic             dc_q, dc_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_end;
    logic [8:0]       hdr_e;

    assign bit_end = (div_cnt_q == DIV_LAST);
    assign hdr_e   = hdr_entry(hdr_idx_q);

    // NOTE: every variable gets its hold/default value first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        hdr_idx_d = hdr_idx_q;
        pix_cnt_d = pix_cnt_q;
        shreg_d   = shreg_q;
        fb_cnt_d  = (fb_cnt_q != 2'd0) ? fb_cnt_q - 2'd1 : 2'd0;
        fbclk_d   = (fb_cnt_q != 2'd0);
        sck_d     = sck_q;
        dc_d      = dc_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Park the divider at end-of-bit so the first header bit loads next edge.
                    state_d   = HDR;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    div_cnt_d = DIV_LAST;
                    bit_cnt_d = 4'd0;
                    hdr_idx_d = 4'd0;
                    pix_cnt_d = 17'd0;
                    shreg_d   = 16'h0000;
                    sck_d     = 1'b0;
                end
            end
            HDR, PIX: begin
                div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;
                sck_d     = (div_cnt_d >= DIV_HALF);
                if (bit_end) begin
                    if (bit_cnt_q != 4'd0) begin
                        shreg_d   = {shreg_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end else if (state_q == HDR && hdr_idx_q != HDR_BYTES) begin
                        shreg_d   = {hdr_e[7:0], 8'h00};
                        dc_d      = hdr_e[8];
                        bit_cnt_d = 4'd7;
                        hdr_idx_d = hdr_idx_q + 4'd1;
                    end else if (state_q == HDR || pix_cnt_q != PIX_LAST) begin
                        if (state_q == PIX) pix_cnt_d = pix_cnt_q + 17'd1;
                        state_d   = PIX;
                        shreg_d   = lcd.pixel_color;
                        dc_d      = 1'b1;
                        bit_cnt_d = 4'd15;
                        fb_cnt_d  = 2'd2;
                    end else begin
                        state_d   = DONE;
                        shreg_d   = 16'h0000;
                        div_cnt_d = '0;
                        sck_d     = 1'b0;
                        cs_n_d    = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= 4'd0;
            hdr_idx_q <= 4'd0;
            pix_cnt_q <= 17'd0;
            shreg_q   <= 16'h0000;
            fb_cnt_q  <= 2'd0;
            fbclk_q   <= 1'b0;
            sck_q     <= 1'b0;
            dc_q      <= 1'b1;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            hdr_idx_q <= hdr_idx_d;
            pix_cnt_q <= pix_cnt_d;
            shreg_q   <= shreg_d;
            fb_cnt_q  <= fb_cnt_d;
            fbclk_q   <= fbclk_d;
            sck_q     <= sck_d;
            dc_q      <= dc_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign lcd.framebufferClk = fbclk_q;
    assign lcd.lcd_sck        = sck_q;
    assign lcd.lcd_mosi       = shreg_q[15];
    assign lcd.lcd_dc         = dc_q;
    assign lcd.lcd_cs_n       = cs_n_q;
    assign busy               = busy_q;
    assign frame_done         = done_q;

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Bench for lcd_frame_streamer on a 4x3 panel with SPI_DIV=1: decodes the SPI stream
// against an expected byte/word list and models the renderer as 0x1000 + pixel index.
module tb_lcd_frame_streamer;

    localparam int W          = 4;
    localparam int H          = 3;
    localparam int DIV        = 1;
    localparam int NPIX       = W * H;
    localparam int FRAME_BITS = 88 + 16 * NPIX;
    localparam int LAT        = 1 + 2 * DIV * FRAME_BITS;
    localparam int PIX_OFF    = 1 + 2 * DIV * 88 + 1;
    localparam int WORD_CLK   = 32 * DIV;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy, frame_done;

    lcd_frame_streamer_if bus();

    lcd_frame_streamer #(.LCD_W(W), .LCD_H(H), .SPI_DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .lcd        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitors, renderer stub and expected stream.
    bit   rx_bits[$];
    bit   rx_dcs[$];
    int   sck_rise[$], fb_rise[$], done_at[$], busy_rise[$], busy_fall[$];
    int   rend_idx = 0;
    logic sck_prev = 1'b0, fb_prev = 1'b0, busy_prev = 1'b0;

    int          unit_len[$];
    logic [15:0] unit_val[$];
    bit          unit_dc[$];

    int n_checks = 0;
    int n_errors = 0;

    assign bus.pixel_color = 16'h1000 + 16'(rend_idx);

    always @(negedge clk) begin
        if (!reset_n) rend_idx = 0;
        if (bus.lcd_sck === 1'b1 && sck_prev !== 1'b1) begin
            rx_bits.push_back(bus.lcd_mosi);
            rx_dcs.push_back(bus.lcd_dc);
            sck_rise.push_back(cyc);
        end
        if (bus.framebufferClk === 1'b1 && fb_prev !== 1'b1) begin
            fb_rise.push_back(cyc);
            rend_idx = (rend_idx + 1) % NPIX;
        end
        if (frame_done === 1'b1) done_at.push_back(cyc);
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise.push_back(cyc);
        if (busy === 1'b0 && busy_prev === 1'b1) busy_fall.push_back(cyc);
        sck_prev  = bus.lcd_sck;
        fb_prev   = bus.framebufferClk;
        busy_prev = busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_bits.delete();
        rx_dcs.delete();
        sck_rise.delete();
        fb_rise.delete();
        done_at.delete();
        busy_rise.delete();
        busy_fall.delete();
    endtask

    // {cs_n, sck, mosi, dc, fbclk, busy, frame_done} must read 1,0,0,1,0,0,0.
    task automatic check_idle_outputs(input string name);
        check(name, 32'({bus.lcd_cs_n, bus.lcd_sck, bus.lcd_mosi, bus.lcd_dc,
                         bus.framebufferClk, busy, frame_done}), 32'b1001000);
    endtask

    task automatic check_frame(input string tag, input int off);
        int pos;
        logic [15:0] v, d;
        pos = off;
        if (rx_bits.size() < off + FRAME_BITS) begin
            check({tag, " bit count"}, rx_bits.size(), off + FRAME_BITS);
            return;
        end
        for (int u = 0; u < unit_len.size(); u++) begin
            v = '0;
            d = '0;
            for (int b = 0; b < unit_len[u]; b++) begin
                v = {v[14:0], rx_bits[pos]};
                d = {d[14:0], rx_dcs[pos]};
                pos++;
            end
            check($sformatf("%s unit%0d data", tag, u), v, unit_val[u]);
            check($sformatf("%s unit%0d dc", tag, u), d,
                  unit_dc[u] ? (16'hFFFF >> (16 - unit_len[u])) : 16'h0000);
        end
    endtask

    task automatic run_scenario(input string tag, input int pa, input int pb, input int exp_frames);
        int e0, rel, bad;
        clear_mon();
        repeat ($urandom_range(1, 8)) tick();
        start = 1'b1;
        e0 = cyc + 1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            rel   = cyc + 1 - e0;
            start = (rel == pa) || (rel == pb);
            tick();
        end
        start = 1'b0;

        check({tag, " frames"}, done_at.size(), exp_frames);
        check({tag, " busy rises"}, busy_rise.size(), exp_frames);
        check({tag, " latency"}, (done_at.size() > 0) ? done_at[0] - e0 : -1, LAT);
        check({tag, " busy falls with done"},
              (busy_fall.size() > 0 && done_at.size() > 0) ? busy_fall[0] - done_at[0] : -1, 0);
        check({tag, " total bits"}, rx_bits.size(), exp_frames * FRAME_BITS);
        check({tag, " first sck rise"}, (sck_rise.size() > 0) ? sck_rise[0] - e0 : -1, 1 + DIV);
        bad = 0;
        for (int i = 1; i < sck_rise.size() && i < FRAME_BITS; i++)
            if (sck_rise[i] - sck_rise[i-1] != 2 * DIV) bad++;
        check({tag, " sck spacing"}, bad, 0);
        check({tag, " fb pulses"}, fb_rise.size(), exp_frames * NPIX);
        check({tag, " first fb rise"}, (fb_rise.size() > 0) ? fb_rise[0] - e0 : -1, PIX_OFF);
        bad = 0;
        for (int i = 1; i < fb_rise.size() && i < NPIX; i++)
            if (fb_rise[i] - fb_rise[i-1] != WORD_CLK) bad++;
        check({tag, " fb spacing"}, bad, 0);
        check_frame(tag, 0);
        if (exp_frames > 1) begin
            check({tag, " gap done->busy"},
                  (busy_rise.size() > 1) ? busy_rise[1] - done_at[0] : -1, 2);
            check({tag, " latency2"},
                  (done_at.size() > 1 && busy_rise.size() > 1) ? done_at[1] - busy_rise[1] : -1, LAT);
            check_frame({tag, " f2"}, FRAME_BITS);
        end
    endtask

    typedef struct {
        int pulse_a;
        int pulse_b;
        int exp_frames;
    } scen_t;

    initial begin
        logic [7:0] hdr [11];
        scen_t tbl [6];
        int e0;

        // Expected unit stream: window header then pixel words 0x1000 + k.
        hdr = '{8'h2A, 8'h00, 8'h00, 8'((W - 1) >> 8), 8'(W - 1),
                8'h2B, 8'h00, 8'h00, 8'((H - 1) >> 8), 8'(H - 1), 8'h2C};
        for (int i = 0; i < 11; i++) begin
            unit_len.push_back(8);
            unit_val.push_back(16'(hdr[i]));
            unit_dc.push_back(!(i == 0 || i == 5 || i == 10));
        end
        for (int k = 0; k < NPIX; k++) begin
            unit_len.push_back(16);
            unit_val.push_back(16'h1000 + 16'(k));
            unit_dc.push_back(1'b1);
        end

        tbl[0] = '{-1, -1, 1};
        tbl[1] = '{5, 300, 1};
        tbl[2] = '{int'($urandom_range(1, 560)), int'($urandom_range(1, 560)), 1};
        tbl[3] = '{int'($urandom_range(1, 560)), int'($urandom_range(1, 560)), 1};
        tbl[4] = '{562, -1, 1};
        tbl[5] = '{563, -1, 2};

        // Reset, then idle with start low.
        repeat (3) tick();
        check_idle_outputs("reset values");
        reset_n = 1'b1;
        clear_mon();
        for (int i = 0; i < 100; i++) begin
            tick();
            check_idle_outputs("idle outputs");
        end
        check("idle sck edges", sck_rise.size(), 0);
        check("idle fb edges", fb_rise.size(), 0);

        for (int r = 0; r < 6; r++)
            run_scenario($sformatf("row%0d", r), tbl[r].pulse_a, tbl[r].pulse_b, tbl[r].exp_frames);

        // Start held high for three frames.
        clear_mon();
        tick();
        start = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (done_at.size() >= 3) break;
        end
        start = 1'b0;
        repeat (10) tick();
        check("held frames", done_at.size(), 3);
        check("held busy rises", busy_rise.size(), 3);
        check("held latency1", (done_at.size() > 0) ? done_at[0] - e0 : -1, LAT);
        for (int k = 1; k < 3; k++) begin
            check($sformatf("held gap%0d", k),
                  (busy_rise.size() > k && done_at.size() > k) ? busy_rise[k] - done_at[k-1] : -1, 2);
            check($sformatf("held latency%0d", k + 1),
                  (busy_rise.size() > k && done_at.size() > k) ? done_at[k] - busy_rise[k] : -1, LAT);
        end
        check("held fb pulses", fb_rise.size(), 3 * NPIX);
        for (int k = 0; k < 3; k++) check_frame($sformatf("held f%0d", k + 1), k * FRAME_BITS);

        // Reset in the middle of the pixel phase.
        clear_mon();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (fb_rise.size() >= 6) break;
        end
        check("midreset reached pixel 5", fb_rise.size(), 6);
        repeat ($urandom_range(0, 20)) tick();
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset async");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_outputs("midreset held");
        end
        reset_n = 1'b1;
        tick();
        run_scenario("after reset", -1, -1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
